// File: rtl/bp_me_pkg.sv
// bp_me_pkg: BedRock memory message types and helpers shared by uncached endpoints
package bp_me_pkg;
    localparam int paddr_width_gp    = 40;
    localparam int fill_width_gp     = 128;
    localparam int fill_bytes_gp     = fill_width_gp / 8;
    localparam int fill_off_width_gp = $clog2(fill_bytes_gp);
    localparam int payload_width_gp  = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_gp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    typedef enum logic [1:0] {e_ready, e_rdata, e_resp} bp_me_spm_state_e;

    function automatic logic size_fits(bp_bedrock_msg_size_e size);
        return size <= e_bedrock_msg_size_16;
    endfunction

    function automatic logic [fill_off_width_gp-1:0] align_mask(bp_bedrock_msg_size_e size);
        return fill_off_width_gp'((32'd1 << size) - 32'd1);
    endfunction

    function automatic logic [fill_bytes_gp-1:0] byte_mask(bp_bedrock_msg_size_e size,
                                                          logic [fill_off_width_gp-1:0] off);
        return fill_bytes_gp'(((32'd1 << (32'd1 << size)) - 32'd1) << off);
    endfunction

    // Repeat the low 2^size bytes across the whole fill width
    function automatic logic [fill_width_gp-1:0] replicate(logic [fill_width_gp-1:0] d,
                                                          bp_bedrock_msg_size_e size);
        logic [fill_width_gp-1:0] r;
        int n;
        n = size_fits(size) ? (1 << size) : fill_bytes_gp;
        r = '0;
        for (int i = 0; i < fill_bytes_gp; i++) r[i*8 +: 8] = d[(i % n)*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/bp_me_spm_decode.sv
// bp_me_spm_decode: scratchpad window, size/alignment legality and byte-lane decode
module bp_me_spm_decode import bp_me_pkg::*; #(
    parameter int els_p = 512,
    parameter logic [paddr_width_gp-1:0] base_addr_p = '0,
    localparam int idx_width_lp = $clog2(els_p)
) (
    input  logic [paddr_width_gp-1:0]    addr_i,
    input  bp_bedrock_msg_size_e         size_i,
    output logic                         legal_o,
    output logic [idx_width_lp-1:0]      index_o,
    output logic [fill_bytes_gp-1:0]     mask_o,
    output logic [fill_off_width_gp-1:0] shift_o
);
    logic [paddr_width_gp-1:0] off;
    logic in_range;

    assign off      = addr_i - base_addr_p;
    assign in_range = (addr_i >= base_addr_p) && (off < paddr_width_gp'(els_p * fill_bytes_gp));
    assign shift_o  = off[fill_off_width_gp-1:0];
    assign index_o  = off[fill_off_width_gp +: idx_width_lp];
    assign mask_o   = byte_mask(size_i, shift_o);
    assign legal_o  = in_range && size_fits(size_i) && ((shift_o & align_mask(size_i)) == '0);
endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port synchronous SRAM with byte write enables
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int data_width_p = 128,
    parameter int els_p = 512,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int bytes_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [bytes_lp-1:0]      write_mask_i,
    output logic [data_width_p-1:0]  data_o
);
    logic [data_width_p-1:0] mem_q [els_p];
    logic [data_width_p-1:0] data_q;

    assign data_o = data_q;

    // Masked byte-lane writes; reads return the addressed word one cycle later
    always_ff @(posedge clk_i) begin
        if (v_i & w_i)
            for (int b = 0; b < bytes_lp; b++)
                if (write_mask_i[b]) mem_q[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
        if (v_i & ~w_i) data_q <= mem_q[addr_i];
    end
endmodule

// File: rtl/bp_me_accel_spm_responder.sv
// bp_me_accel_spm_responder: uncached BedRock read/write responder over a private scratchpad
module bp_me_accel_spm_responder import bp_me_pkg::*; #(
    parameter int els_p = 512,
    parameter logic [paddr_width_gp-1:0] base_addr_p = '0,
    localparam int idx_width_lp = $clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  bp_bedrock_mem_header_s mem_fwd_header_i,
    input  logic [fill_width_gp-1:0] mem_fwd_data_i,
    input  logic                   mem_fwd_v_i,
    output logic                   mem_fwd_ready_and_o,
    output bp_bedrock_mem_header_s mem_rev_header_o,
    output logic [fill_width_gp-1:0] mem_rev_data_o,
    output logic                   mem_rev_v_o,
    input  logic                   mem_rev_ready_and_i,
    output logic                   error_o
);
    bp_me_spm_state_e state_q, state_d;
    bp_bedrock_mem_header_s hdr_q, hdr_d;
    logic [fill_width_gp-1:0] data_q, data_d, sram_data;
    logic error_q, error_d;
    logic fwd_hs, rev_hs, is_uc_rd, is_uc_wr, legal, accept;
    logic [paddr_width_gp-1:0] dec_addr;
    bp_bedrock_msg_size_e dec_size;
    logic [idx_width_lp-1:0] index;
    logic [fill_bytes_gp-1:0] mask;
    logic [fill_off_width_gp-1:0] shift;

    assign mem_fwd_ready_and_o = (state_q == e_ready) & ~reset_i;
    assign mem_rev_v_o         = state_q == e_resp;
    assign mem_rev_header_o    = hdr_q;
    assign mem_rev_data_o      = data_q;
    assign error_o             = error_q;
    assign fwd_hs   = mem_fwd_v_i & mem_fwd_ready_and_o;
    assign rev_hs   = mem_rev_v_o & mem_rev_ready_and_i;
    assign is_uc_rd = mem_fwd_header_i.msg_type == e_bedrock_mem_uc_rd;
    assign is_uc_wr = mem_fwd_header_i.msg_type == e_bedrock_mem_uc_wr;
    assign accept   = legal & (is_uc_rd | is_uc_wr);
    // Decode the incoming header while idle, the latched one while aligning read data
    assign dec_addr = (state_q == e_ready) ? mem_fwd_header_i.addr : hdr_q.addr;
    assign dec_size = (state_q == e_ready) ? mem_fwd_header_i.size : hdr_q.size;

    bp_me_spm_decode #(.els_p(els_p), .base_addr_p(base_addr_p)) decode (
        .addr_i(dec_addr),
        .size_i(dec_size),
        .legal_o(legal),
        .index_o(index),
        .mask_o(mask),
        .shift_o(shift)
    );

    bsg_mem_1rw_sync_mask_write_byte #(.data_width_p(fill_width_gp), .els_p(els_p)) sram (
        .clk_i(clk_i),
        .v_i(fwd_hs & accept),
        .w_i(is_uc_wr),
        .addr_i(index),
        .data_i(replicate(mem_fwd_data_i, mem_fwd_header_i.size)),
        .write_mask_i(mask),
        .data_o(sram_data)
    );

    // Accept one fwd message, optionally wait a cycle for SRAM data, then hold the response
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        error_d = error_q;
        case (state_q)
            e_ready: if (fwd_hs) begin
                hdr_d   = mem_fwd_header_i;
                data_d  = '0;
                error_d = error_q | ~accept;
                state_d = (accept & is_uc_rd) ? e_rdata : e_resp;
            end
            e_rdata: begin
                data_d  = replicate(sram_data >> {shift, 3'b000}, hdr_q.size);
                state_d = e_resp;
            end
            e_resp:  state_d = rev_hs ? e_ready : e_resp;
            default: state_d = e_ready;
        endcase
    end

    // State and response registers; reset drops any pending response
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_bp_me_accel_spm_responder.sv
// tb_bp_me_accel_spm_responder: directed vector bench for the scratchpad responder
module tb_bp_me_accel_spm_responder;
    import bp_me_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    bp_bedrock_mem_header_s mem_fwd_header_i = '0;
    logic [127:0] mem_fwd_data_i = '0;
    logic mem_fwd_v_i = 1'b0;
    logic mem_fwd_ready_and_o;
    bp_bedrock_mem_header_s mem_rev_header_o;
    logic [127:0] mem_rev_data_o;
    logic mem_rev_v_o;
    logic mem_rev_ready_and_i = 1'b1;
    logic error_o;

    bp_me_accel_spm_responder dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .mem_fwd_header_i(mem_fwd_header_i),
        .mem_fwd_data_i(mem_fwd_data_i),
        .mem_fwd_v_i(mem_fwd_v_i),
        .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
        .mem_rev_header_o(mem_rev_header_o),
        .mem_rev_data_o(mem_rev_data_o),
        .mem_rev_v_o(mem_rev_v_o),
        .mem_rev_ready_and_i(mem_rev_ready_and_i),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int rev_cnt = 0;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) if (mem_rev_v_o && mem_rev_ready_and_i) rev_cnt <= rev_cnt + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bp_bedrock_mem_type_e msg;
        logic [39:0] addr;
        bp_bedrock_msg_size_e size;
        logic [127:0] wdata;
        logic [127:0] exp_data;
        int exp_lat;
        logic exp_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] d0_c  = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] d1_c  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] d1m_c = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_7654_3210;

    function automatic vec_t mk(bp_bedrock_mem_type_e msg, logic [39:0] addr, bp_bedrock_msg_size_e size,
                                logic [127:0] wdata, logic [127:0] exp_data, int exp_lat, logic exp_err);
        vec_t v;
        v.msg = msg; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input bp_bedrock_mem_type_e msg, input logic [39:0] addr,
                        input bp_bedrock_msg_size_e size, input logic [127:0] wdata, input logic [15:0] tag,
                        output logic [127:0] rdata, output bp_bedrock_mem_header_s rhdr,
                        output int lat, output int hs_cyc);
        int n;
        @(negedge clk_i);
        mem_fwd_header_i = '{payload: tag, size: size, addr: addr, subop: 4'h0, msg_type: msg};
        mem_fwd_data_i = wdata;
        mem_fwd_v_i = 1'b1;
        n = 0;
        while (!mem_fwd_ready_and_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        hs_cyc = cyc;
        mem_fwd_v_i = 1'b0;
        lat = 1;
        while (!mem_rev_v_o && lat < 10) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        rdata = mem_rev_data_o;
        rhdr = mem_rev_header_o;
        if (mem_rev_ready_and_i) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] rd;
        bp_bedrock_mem_header_s rh, eh;
        int lat, hs, hs_prev, bad, cnt0;

        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h000, e_bedrock_msg_size_16, d0_c, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h020, e_bedrock_msg_size_16, d1_c, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h020, e_bedrock_msg_size_16, '0, d1_c, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h024, e_bedrock_msg_size_4, 128'hDEADBEEF, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h020, e_bedrock_msg_size_16, '0, d1m_c, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h024, e_bedrock_msg_size_4, '0, {4{32'hDEADBEEF}}, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h026, e_bedrock_msg_size_2, '0, {8{16'hDEAD}}, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h021, e_bedrock_msg_size_1, '0, {16{8'h32}}, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h030, e_bedrock_msg_size_16, '0, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h031, e_bedrock_msg_size_1, 128'hA5, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h038, e_bedrock_msg_size_8, 128'h1122334455667788, '0, 1, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h030, e_bedrock_msg_size_16, '0,
                          {64'h1122334455667788, 64'h000000000000A500}, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h030, e_bedrock_msg_size_8, '0, {2{64'h000000000000A500}}, 2, 1'b0));
        vecs.push_back(mk(e_bedrock_mem_amo, 40'h020, e_bedrock_msg_size_16, d1_c, '0, 1, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h2000, e_bedrock_msg_size_16, '1, '0, 1, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h000, e_bedrock_msg_size_16, '0, d0_c, 2, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_uc_wr, 40'h002, e_bedrock_msg_size_4, '1, '0, 1, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h000, e_bedrock_msg_size_16, '0, d0_c, 2, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_rd, 40'h000, e_bedrock_msg_size_16, '0, '0, 1, 1'b1));
        vecs.push_back(mk(e_bedrock_mem_uc_rd, 40'h000, e_bedrock_msg_size_32, '0, '0, 1, 1'b1));

        // reset state
        repeat (3) @(negedge clk_i);
        check("reset fwd_ready", 128'(mem_fwd_ready_and_o), 128'(0));
        check("reset rev_v", 128'(mem_rev_v_o), 128'(0));
        check("reset error", 128'(error_o), 128'(0));
        reset_i = 1'b0;
        #1;
        check("post-reset fwd_ready", 128'(mem_fwd_ready_and_o), 128'(1));
        @(posedge clk_i);
        #1;
        check("post-reset rev_v", 128'(mem_rev_v_o), 128'(0));
        check("post-reset rev_data", mem_rev_data_o, '0);
        check("post-reset rev_hdr", 128'(mem_rev_header_o), '0);

        // table-driven vectors
        foreach (vecs[i]) begin
            send(vecs[i].msg, vecs[i].addr, vecs[i].size, vecs[i].wdata, 16'(i), rd, rh, lat, hs);
            eh = '{payload: 16'(i), size: vecs[i].size, addr: vecs[i].addr, subop: 4'h0, msg_type: vecs[i].msg};
            check($sformatf("v%0d data", i), rd, vecs[i].exp_data);
            check($sformatf("v%0d latency", i), 128'(lat), 128'(vecs[i].exp_lat));
            check($sformatf("v%0d header", i), 128'(rh), 128'(eh));
            check($sformatf("v%0d error", i), 128'(error_o), 128'(vecs[i].exp_err));
        end

        // back-pressure: response must hold while rev is not ready
        cnt0 = rev_cnt;
        mem_rev_ready_and_i = 1'b0;
        send(e_bedrock_mem_uc_rd, 40'h020, e_bedrock_msg_size_16, '0, 16'h77, rd, rh, lat, hs);
        check("bp latency", 128'(lat), 128'(2));
        check("bp data", rd, d1m_c);
        bad = 0;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            if (!mem_rev_v_o || mem_rev_data_o !== rd || mem_rev_header_o !== rh || mem_fwd_ready_and_o) bad++;
        end
        check("bp stable cycles", 128'(bad), 128'(0));
        @(negedge clk_i);
        mem_rev_ready_and_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("bp release rev_v", 128'(mem_rev_v_o), 128'(0));
        check("bp release fwd_ready", 128'(mem_fwd_ready_and_o), 128'(1));
        check("bp single handshake", 128'(rev_cnt - cnt0), 128'(1));

        // streaming writes, then readback sweep
        cnt0 = rev_cnt;
        hs_prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(e_bedrock_mem_uc_wr, 40'h100 + 40'(16 * i), e_bedrock_msg_size_16, {4{32'(i + 1)}},
                 16'(8'h40 + i), rd, rh, lat, hs);
            check($sformatf("stream w%0d data", i), rd, '0);
            check($sformatf("stream w%0d order", i), 128'(rh.payload), 128'(8'h40 + i));
            if (i > 0) check($sformatf("stream w%0d spacing", i), 128'(hs - hs_prev), 128'(2));
            hs_prev = hs;
        end
        check("stream response count", 128'(rev_cnt - cnt0), 128'(8));
        for (int i = 0; i < 8; i++) begin
            send(e_bedrock_mem_uc_rd, 40'h100 + 40'(16 * i), e_bedrock_msg_size_16, '0, 16'(i), rd, rh, lat, hs);
            check($sformatf("sweep r%0d data", i), rd, {4{32'(i + 1)}});
            check($sformatf("sweep r%0d latency", i), 128'(lat), 128'(2));
        end

        // reset while a read is waiting on SRAM data, with a fwd valid held during reset
        @(negedge clk_i);
        mem_fwd_header_i = '{payload: 16'h0, size: e_bedrock_msg_size_16, addr: 40'h100, subop: 4'h0,
                             msg_type: e_bedrock_mem_uc_rd};
        mem_fwd_v_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        mem_fwd_header_i.msg_type = e_bedrock_mem_uc_wr;
        check("rst fwd_ready low", 128'(mem_fwd_ready_and_o), 128'(0));
        @(posedge clk_i);
        #1;
        check("rst rev_v dropped", 128'(mem_rev_v_o), 128'(0));
        check("rst error cleared", 128'(error_o), 128'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        mem_fwd_v_i = 1'b0;
        #1;
        check("rst release fwd_ready", 128'(mem_fwd_ready_and_o), 128'(1));
        @(posedge clk_i);
        #1;
        check("rst no stray response", 128'(mem_rev_v_o), 128'(0));
        check("rst error stays clear", 128'(error_o), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_me_accel_spm_responder.md
Name: bp_me_accel_spm_responder

Overview:
- BedRock memory-side responder terminating the uncached write stream an accelerator pipe issues (e_bedrock_mem_uc_wr, 16 B) plus uncached reads for readback.
- Sits on an L2-side mem_fwd/mem_rev port in front of a private scratchpad SRAM.
- Stores or fetches one fill-width word per message and returns one mem_rev beat per mem_fwd message.
- Flags unsupported or out-of-range traffic without ever deadlocking the interface.

Parameters:
- bp_params_p, e_bp_default_cfg: processor configuration; supplies paddr_width_p, bedrock_fill_width_p (128 in the default config), did_width_p, lce_id_width_p, lce_assoc_p.
- els_p, 512: scratchpad depth in fill-width words.
- base_addr_p, 0: byte base address of the scratchpad window.

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- mem_fwd_header_i  in  mem_fwd_header_width_lp  BedRock fwd header.
- mem_fwd_data_i  in  bedrock_fill_width_p  fwd data beat.
- mem_fwd_v_i  in  1  fwd valid.
- mem_fwd_ready_and_o  out  1  fwd ready-and handshake.
- mem_rev_header_o  out  mem_rev_header_width_lp  rev header.
- mem_rev_data_o  out  bedrock_fill_width_p  rev data beat.
- mem_rev_v_o  out  1  rev valid.
- mem_rev_ready_and_i  in  1  rev ready-and handshake.
- error_o  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Clocking and handshakes: one clock; reset is synchronous and active-high on reset_i. All handshakes are ready-and; a transfer occurs on v & ready in the same cycle.
- Reset values: mem_fwd_ready_and_o=0 during reset and 1 in the first idle cycle after it; mem_rev_v_o=0; error_o=0; header and data registers cleared; FSM in e_ready.
- FSM states: e_ready, e_rdata, e_resp.
- e_ready: mem_fwd_ready_and_o=1. On a fwd handshake at cycle T, latch the header into hdr_r, then:
  - uc_wr, in range: masked SRAM write at T; go to e_resp. mem_rev_v_o rises at T+1; rev data=0.
  - uc_rd, in range: SRAM read at T; go to e_rdata. At T+1, capture the SRAM output (aligned, then replicated) into data_r; go to e_resp. mem_rev_v_o rises at T+2.
  - Any other msg_type (mem_rd, mem_wr, amo, ...): no SRAM access, error_o set, go to e_resp with data 0.
- e_rdata and e_resp: mem_fwd_ready_and_o=0, so there is no fwd overlap.
- e_resp: mem_rev_v_o=1. Header equals hdr_r, with msg_type, addr, size, subop and payload copied unchanged. Outputs hold stable until mem_rev_ready_and_i; on that handshake return to e_ready. Back-to-back messages therefore take at least 2 cycles for writes and 3 for reads.
- Address decoding:
  - off = addr - base_addr_p.
  - index = off[fill_bytes_lp offset bits +: clog2(els_p)].
  - byte offset = off low log2(fill_bytes_lp) bits.
  - In range iff addr >= base_addr_p and off < els_p * fill_bytes_lp.
- Size rules: size must be <= fill width (16 B at default) and aligned (byte offset a multiple of the size).
  - Violations and out-of-range addresses: no SRAM access, error_o set, response still returned (wr: data 0; rd: data 0).
- Write mask: (2^size bytes) of ones shifted by the byte offset. Write data is taken from the low 2^size bytes of mem_fwd_data_i, replicated per the BedRock convention, so the byte lane at the offset carries the data.
- Read data: the SRAM word is shifted right by the byte offset, truncated to 2^size bytes, and replicated across the fill width.
- Reset asserted mid-operation: any pending response is dropped, the FSM returns to e_ready, and error_o is cleared. SRAM contents are unspecified after reset.
- Reset concurrent with mem_fwd_v_i: no handshake occurs, because ready is 0 during reset.

Decomposition:
- Shared package (bp_me_pkg):
  - enum bp_me_spm_state_e {e_ready, e_rdata, e_resp}.
  - Mask, align and replicate helper functions, reusable by other BedRock uncached endpoints.
- Sub-module: bp_me_spm_decode, purely combinational. Produces in-range/legal flags, index, byte mask and shift amount from the header.
- Storage: bsg_mem_1rw_sync_mask_write_byte instance, width bedrock_fill_width_p, depth els_p.

Test Plan:
1. Write then read back: uc_wr addr=base+0x20, size 16 B, data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → rev at T+1, data 0. Then uc_rd addr=base+0x20, size 16 B → rev at T+2 with identical data; error_o=0.
2. Sub-word write: uc_wr addr=base+0x24, size 4 B, data low word 32'hDEADBEEF; then uc_rd 16 B at base+0x20 → only bytes 4..7 become EF BE AD DE; then uc_rd 4 B at base+0x24 → data replicated 32'hDEADBEEF x4.
3. Back-pressure: hold mem_rev_ready_and_i=0 for 5 cycles during e_resp → mem_rev_v_o, header and data stable; mem_fwd_ready_and_o=0 throughout; a single handshake on release.
4. Illegal traffic:
   - e_bedrock_mem_amo → response returned, error_o=1.
   - addr=base+els_p*16 → error_o=1; SRAM unchanged, verified by a readback of index 0.
5. Streaming: 8 consecutive uc_wr, addr +16 each with incrementing data, mem_rev_ready_and_i=1 → 8 responses in order, 2-cycle spacing; a readback sweep matches.
6. Reset in e_rdata → mem_rev_v_o=0 the next cycle, mem_fwd_ready_and_o=1 in the first cycle after reset deasserts, error_o=0.
